// File: rtl/p4_router_egress_demux_if.sv
// AXI-Stream bundle used on both sides of the egress demux; tuser carries {ingress port, egress spec}.
// The master drives the payload and tvalid, the slave drives tready.
interface p4_router_egress_demux_if #(
    parameter int DATA_BYTES = 8,
    parameter int USER_WIDTH = 3
);
    logic                    tvalid;
    logic                    tready;
    logic [DATA_BYTES*8-1:0] tdata;
    logic [DATA_BYTES-1:0]   tkeep;
    logic                    tlast;
    logic [USER_WIDTH-1:0]   tuser;

    modport master (output tvalid, tdata, tkeep, tlast, tuser, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, tuser, output tready);
endinterface

// File: rtl/p4_router_egress_demux.sv
// Steers each packet to the egress port named by its first-beat egress spec; invalid specs are discarded.
// One-cycle latency through a shared output slice; drops consume at full rate, forwards follow the selected port's tready.
module p4_router_egress_demux #(
    parameter int NUM_PORTS               = 4,
    parameter int EGR_SPEC_METADATA_WIDTH = 2,
    parameter int ING_PORT_METADATA_WIDTH = 1,
    parameter int USER_METADATA_WIDTH     = EGR_SPEC_METADATA_WIDTH + ING_PORT_METADATA_WIDTH,
    parameter int DATA_BYTES              = 8
) (
    input  logic                              clk,
    input  logic                              sreset,
    p4_router_egress_demux_if.slave           packet_data_in,
    p4_router_egress_demux_if.master          packet_data_out [NUM_PORTS],
    output logic                              drop_pulse,
    output logic [31:0]                       drop_count,
    output logic [31:0]                       fwd_count
);
    localparam int PORT_W = $clog2(NUM_PORTS);
    localparam int EW     = EGR_SPEC_METADATA_WIDTH;
    localparam int UW     = USER_METADATA_WIDTH;
    localparam int DW     = DATA_BYTES * 8;

    if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
        $error("NUM_PORTS must be in 2..16");
    end
    if (EW < PORT_W || EW > 16) begin : g_bad_spec_width
        $error("EGR_SPEC_METADATA_WIDTH must be in clog2(NUM_PORTS)..16");
    end
    if (ING_PORT_METADATA_WIDTH < 1 || UW != EW + ING_PORT_METADATA_WIDTH) begin : g_bad_user_width
        $error("USER_METADATA_WIDTH must equal the egress-spec plus ingress-port widths");
    end

    typedef enum logic [1:0] {ST_SOP, ST_FWD, ST_DROP} state_t;

    state_t              state_q, state_d;
    logic [PORT_W-1:0]   port_q, port_d;
    logic                out_vld_q, out_vld_d;
    logic [PORT_W-1:0]   out_port_q, out_port_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic [DATA_BYTES-1:0] out_keep_q, out_keep_d;
    logic                out_last_q, out_last_d;
    logic [UW-1:0]       out_user_q, out_user_d;
    logic                drop_pulse_q, drop_pulse_d;
    logic [31:0]         drop_count_q, drop_count_d;
    logic [31:0]         fwd_count_q, fwd_count_d;

    logic [NUM_PORTS-1:0] out_rdy_vec;
    logic [EW-1:0]        in_spec;
    logic                 spec_ok;
    logic                 out_rdy_sel;
    logic                 slice_rdy;
    logic                 out_hs;
    logic                 in_rdy;
    logic                 in_hs;
    logic                 fwd_acc;
    logic                 drop_last;

    // All-ones is an explicit drop even when it would otherwise name a real port.
    assign in_spec     = packet_data_in.tuser[EW-1:0];
    assign spec_ok     = (32'(in_spec) < 32'(NUM_PORTS)) && (in_spec != {EW{1'b1}});
    assign out_rdy_sel = out_rdy_vec[out_port_q];
    assign slice_rdy   = !out_vld_q || out_rdy_sel;
    assign out_hs      = out_vld_q && out_rdy_sel;
    assign in_hs       = packet_data_in.tvalid && in_rdy;

    assign packet_data_in.tready = in_rdy;
    assign drop_pulse            = drop_pulse_q;
    assign drop_count            = drop_count_q;
    assign fwd_count             = fwd_count_q;

    always_comb begin
        in_rdy = 1'b0;
        if (!sreset) begin
            case (state_q)
                ST_SOP:  in_rdy = spec_ok ? slice_rdy : 1'b1;
                ST_FWD:  in_rdy = slice_rdy;
                ST_DROP: in_rdy = 1'b1;
                default: in_rdy = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        port_d    = port_q;
        fwd_acc   = 1'b0;
        drop_last = 1'b0;
        case (state_q)
            ST_SOP: begin
                if (in_hs) begin
                    if (spec_ok) begin
                        fwd_acc = 1'b1;
                        port_d  = in_spec[PORT_W-1:0];
                        state_d = packet_data_in.tlast ? ST_SOP : ST_FWD;
                    end else begin
                        drop_last = packet_data_in.tlast;
                        state_d   = packet_data_in.tlast ? ST_SOP : ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (in_hs) begin
                    fwd_acc = 1'b1;
                    if (packet_data_in.tlast) state_d = ST_SOP;
                end
            end
            ST_DROP: begin
                if (in_hs && packet_data_in.tlast) begin
                    drop_last = 1'b1;
                    state_d   = ST_SOP;
                end
            end
            default: state_d = ST_SOP;
        endcase
    end

    // A new beat may load in the same cycle the held beat drains, so loading wins over clearing.
    always_comb begin
        out_vld_d    = out_vld_q;
        out_port_d   = out_port_q;
        out_data_d   = out_data_q;
        out_keep_d   = out_keep_q;
        out_last_d   = out_last_q;
        out_user_d   = out_user_q;
        drop_pulse_d = drop_last;
        drop_count_d = drop_count_q;
        fwd_count_d  = fwd_count_q;
        if (fwd_acc) begin
            out_vld_d  = 1'b1;
            out_port_d = (state_q == ST_SOP) ? in_spec[PORT_W-1:0] : port_q;
            out_data_d = packet_data_in.tdata;
            out_keep_d = packet_data_in.tkeep;
            out_last_d = packet_data_in.tlast;
            out_user_d = packet_data_in.tuser;
        end else if (out_hs) begin
            out_vld_d = 1'b0;
        end
        if (out_hs && out_last_q) fwd_count_d = fwd_count_q + 32'd1;
        if (drop_last && drop_count_q != 32'hFFFF_FFFF) drop_count_d = drop_count_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            state_q      <= ST_SOP;
            port_q       <= '0;
            out_vld_q    <= 1'b0;
            out_port_q   <= '0;
            out_data_q   <= '0;
            out_keep_q   <= '0;
            out_last_q   <= 1'b0;
            out_user_q   <= '0;
            drop_pulse_q <= 1'b0;
            drop_count_q <= '0;
            fwd_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            out_vld_q    <= out_vld_d;
            out_port_q   <= out_port_d;
            out_data_q   <= out_data_d;
            out_keep_q   <= out_keep_d;
            out_last_q   <= out_last_d;
            out_user_q   <= out_user_d;
            drop_pulse_q <= drop_pulse_d;
            drop_count_q <= drop_count_d;
            fwd_count_q  <= fwd_count_d;
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_out
        assign packet_data_out[p].tvalid = out_vld_q && (out_port_q == PORT_W'(p));
        assign packet_data_out[p].tdata  = out_data_q;
        assign packet_data_out[p].tkeep  = out_keep_q;
        assign packet_data_out[p].tlast  = out_last_q;
        assign packet_data_out[p].tuser  = out_user_q;
        assign out_rdy_vec[p]            = packet_data_out[p].tready;
    end
endmodule
